// File: rtl/or1200_ic_refill.sv
// Instruction-cache line refill engine: fetches one line as 32-bit bus reads,
// packs word pairs into 64-bit entries and writes them into the IC data RAM.
module or1200_ic_refill #(
  parameter int DW         = 32,
  parameter int RAM_DW     = 64,
  parameter int AW         = 11,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  output logic              miss_ack,
  output logic              busy,
  output logic              refill_done,
  output logic              refill_err,
  output logic              biu_cyc,
  output logic [31:0]       biu_adr,
  input  logic              biu_ack,
  input  logic              biu_err,
  input  logic [DW-1:0]     biu_dat,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_DW-1:0] ram_datain
);

  localparam int              CW        = $clog2(LINE_WORDS) + 1;
  localparam logic [31:0]     LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  logic [CW-1:0] pair_cnt_s;
  logic [31:0]   fetch_adr_s;
  logic [31:0]   wr_byte_s;

  // State and datapath registers; async reset aborts any refill immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= 32'd0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Address arithmetic: cnt counts words already fetched, so the entry being
  // written in WRITE starts two words back from the current count.
  always_comb begin
    pair_cnt_s  = cnt_q - CW'(2);
    fetch_adr_s = base_q + {{(30-CW){1'b0}}, cnt_q, 2'b00};
    wr_byte_s   = base_q + {{(30-CW){1'b0}}, pair_cnt_s, 2'b00};
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    miss_ack    = 1'b0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    biu_cyc     = 1'b0;
    biu_adr     = 32'd0;
    ram_addr    = '0;
    ram_en      = 1'b0;
    ram_we      = 4'h0;
    ram_datain  = '0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // rst gate keeps miss_ack low while reset is held
        if (miss_req && rst) begin
          miss_ack = 1'b1;
          base_d   = miss_addr & LINE_MASK;
          cnt_d    = '0;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_FETCH: begin
        biu_cyc = 1'b1;
        biu_adr = fetch_adr_s;
        if (biu_err) begin
          state_d = S_ERR;
        end else if (biu_ack) begin
          cnt_d = cnt_q + CW'(1);
          if (!cnt_q[0]) begin
            hi_d = biu_dat;
          end else begin
            lo_d    = biu_dat;
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WRITE: begin
        ram_en     = 1'b1;
        ram_we     = 4'hF;
        ram_addr   = AW'(wr_byte_s >> 3);
        ram_datain = {hi_q, lo_q};
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        refill_done = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        refill_err = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_or1200_ic_refill.sv
// Directed bench for or1200_ic_refill: bus responder model plus per-scenario
// tasks with hand-computed expected addresses, data and latencies.
module tb_or1200_ic_refill;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = 32'd0;
  logic         miss_ack, busy, refill_done, refill_err, biu_cyc;
  logic [31:0]  biu_adr;
  logic         biu_ack = 1'b0;
  logic         biu_err = 1'b0;
  logic [31:0]  biu_dat = 32'd0;
  logic [10:0]  ram_addr;
  logic         ram_en;
  logic [3:0]   ram_we;
  logic [63:0]  ram_datain;
  logic [116:0] outs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  or1200_ic_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .busy(busy), .refill_done(refill_done), .refill_err(refill_err),
    .biu_cyc(biu_cyc), .biu_adr(biu_adr), .biu_ack(biu_ack), .biu_err(biu_err),
    .biu_dat(biu_dat), .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_datain(ram_datain)
  );

  assign outs = {miss_ack, busy, refill_done, refill_err, biu_cyc, biu_adr,
                 ram_addr, ram_en, ram_we, ram_datain};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: word k of a refill returns 0x11111111*(k+1) after `waits` idle cycles.
  int          waits = 0;
  int          err_word = -1;
  bit          both = 1'b0;
  int          word_idx = 0;
  int          wait_cnt = 0;
  int          unstable = 0;
  int          n_adr = 0;
  logic [31:0] held_adr = 32'd0;
  logic [31:0] adr_log [16];

  always @(negedge clk) begin
    if (biu_cyc) begin
      if (wait_cnt == 0) held_adr = biu_adr;
      else if (biu_adr !== held_adr) unstable++;
      if (wait_cnt >= waits) begin
        if (n_adr < 16) adr_log[n_adr] = biu_adr;
        n_adr++;
        biu_dat = 32'h11111111 * 32'(word_idx + 1);
        if (word_idx == err_word) begin
          biu_err = 1'b1;
          biu_ack = both;
        end else begin
          biu_err = 1'b0;
          biu_ack = 1'b1;
        end
        word_idx++;
        wait_cnt = 0;
      end else begin
        biu_ack = 1'b0;
        biu_err = 1'b0;
        wait_cnt++;
      end
    end else begin
      biu_ack  = 1'b0;
      biu_err  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Output monitor, sampled mid-cycle.
  int          ack_cnt = 0, ack_cyc = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          err_cnt = 0, err_cyc = 0;
  int          n_wr = 0;
  logic [10:0] wr_addr [16];
  logic [63:0] wr_data [16];
  logic [3:0]  wr_we   [16];

  always begin
    @(negedge clk);
    #2;
    if (miss_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (ram_en) begin
      if (n_wr < 16) begin
        wr_addr[n_wr] = ram_addr;
        wr_data[n_wr] = ram_datain;
        wr_we[n_wr]   = ram_we;
      end
      n_wr++;
    end
    if (refill_done) begin done_cnt++; done_cyc = cyc; end
    if (refill_err)  begin err_cnt++;  err_cyc  = cyc; end
  end

  task automatic clear_logs();
    n_adr = 0; n_wr = 0; word_idx = 0; wait_cnt = 0; unstable = 0;
    ack_cnt = 0; done_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      adr_log[i] = 32'd0; wr_addr[i] = 11'd0; wr_data[i] = 64'd0; wr_we[i] = 4'd0;
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for the done or error pulse.
  task automatic run_req(input logic [31:0] addr, input int budget, output bit timed_out);
    int n0;
    n0 = done_cnt + err_cnt;
    @(negedge clk);
    miss_req  = 1'b1;
    miss_addr = addr;
    @(negedge clk);
    miss_req  = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      #3;
      if (done_cnt + err_cnt != n0) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (outs !== 117'd0) begin n_fail++; $display("FAIL reset_outs got %h exp 0", outs); end
    miss_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (outs !== 117'd0) begin n_fail++; $display("FAIL reset_hold_req got %h exp 0", outs); end
    miss_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    repeat (3) @(negedge clk);
    #3;
    n_tests++;
    if ({busy, biu_cyc, ram_en} !== 3'b000 || n_adr != 0 || n_wr != 0) begin
      n_fail++; $display("FAIL reset_idle got busy=%b cyc=%b reads=%0d writes=%0d exp all 0",
                         busy, biu_cyc, n_adr, n_wr);
    end
  endtask

  task automatic test_line();
    bit to;
    clear_logs(); waits = 0; err_word = -1; both = 1'b0;
    run_req(32'h00001234, 40, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL line_timeout got no done exp done"); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (adr_log[i] !== 32'h00001230 + 32'(4 * i)) begin
        n_fail++; $display("FAIL line_adr%0d got %h exp %h", i, adr_log[i], 32'h00001230 + 32'(4 * i));
      end
    end
    n_tests++;
    if (n_wr != 2 || wr_addr[0] !== 11'h246 || wr_addr[1] !== 11'h247) begin
      n_fail++; $display("FAIL line_wr_addr got n=%0d %h %h exp n=2 246 247", n_wr, wr_addr[0], wr_addr[1]);
    end
    n_tests++;
    if (wr_data[0] !== 64'h11111111_22222222 || wr_data[1] !== 64'h33333333_44444444) begin
      n_fail++; $display("FAIL line_wr_data got %h %h exp 1111111122222222 3333333344444444",
                         wr_data[0], wr_data[1]);
    end
    n_tests++;
    if (wr_we[0] !== 4'hF || wr_we[1] !== 4'hF) begin
      n_fail++; $display("FAIL line_wr_we got %h %h exp f f", wr_we[0], wr_we[1]);
    end
    n_tests++;
    if (done_cyc - ack_cyc != 7 || ack_cnt != 1 || err_cnt != 0) begin
      n_fail++; $display("FAIL line_latency got %0d acks=%0d errs=%0d exp 7 1 0",
                         done_cyc - ack_cyc, ack_cnt, err_cnt);
    end
    @(negedge clk); #3;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL line_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_wait();
    bit to;
    clear_logs(); waits = 3; err_word = -1; both = 1'b0;
    run_req(32'h00001234, 60, to);
    n_tests++;
    if (to || done_cyc - ack_cyc != 19) begin
      n_fail++; $display("FAIL wait_latency got to=%b lat=%0d exp 0 19", to, done_cyc - ack_cyc);
    end
    n_tests++;
    if (unstable != 0 || n_adr != 4 || adr_log[3] !== 32'h0000123C) begin
      n_fail++; $display("FAIL wait_adr_stable got unstable=%0d reads=%0d last=%h exp 0 4 0000123c",
                         unstable, n_adr, adr_log[3]);
    end
    n_tests++;
    if (n_wr != 2 || wr_addr[1] !== 11'h247 || wr_data[1] !== 64'h33333333_44444444) begin
      n_fail++; $display("FAIL wait_writes got n=%0d %h %h exp 2 247 3333333344444444",
                         n_wr, wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_err();
    bit to;
    clear_logs(); waits = 0; err_word = 2; both = 1'b0;
    run_req(32'h00001234, 40, to);
    n_tests++;
    if (to || err_cnt != 1 || done_cnt != 0 || err_cyc - ack_cyc != 5) begin
      n_fail++; $display("FAIL err_pulse got to=%b errs=%0d dones=%0d lat=%0d exp 0 1 0 5",
                         to, err_cnt, done_cnt, err_cyc - ack_cyc);
    end
    n_tests++;
    if (n_wr != 1 || wr_addr[0] !== 11'h246 || wr_data[0] !== 64'h11111111_22222222) begin
      n_fail++; $display("FAIL err_writes got n=%0d %h %h exp 1 246 1111111122222222",
                         n_wr, wr_addr[0], wr_data[0]);
    end
    @(negedge clk); #3;
    n_tests++;
    if (busy !== 1'b0 || biu_cyc !== 1'b0) begin
      n_fail++; $display("FAIL err_idle got busy=%b cyc=%b exp 0 0", busy, biu_cyc);
    end
  endtask

  task automatic test_ack_err();
    bit to;
    clear_logs(); waits = 0; err_word = 0; both = 1'b1;
    run_req(32'h00001234, 40, to);
    n_tests++;
    if (to || err_cnt != 1 || done_cnt != 0 || n_wr != 0 || err_cyc - ack_cyc != 2) begin
      n_fail++; $display("FAIL ack_err got to=%b errs=%0d dones=%0d writes=%0d lat=%0d exp 0 1 0 0 2",
                         to, err_cnt, done_cnt, n_wr, err_cyc - ack_cyc);
    end
  endtask

  task automatic test_wrap();
    bit to;
    clear_logs(); waits = 0; err_word = -1; both = 1'b0;
    run_req(32'hFFFFFFF8, 40, to);
    n_tests++;
    if (to || adr_log[0] !== 32'hFFFFFFF0 || adr_log[3] !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL wrap_adr got to=%b %h %h exp 0 fffffff0 fffffffc", to, adr_log[0], adr_log[3]);
    end
    n_tests++;
    if (n_wr != 2 || wr_addr[0] !== 11'h7FE || wr_addr[1] !== 11'h7FF) begin
      n_fail++; $display("FAIL wrap_ram got n=%0d %h %h exp 2 7fe 7ff", n_wr, wr_addr[0], wr_addr[1]);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    clear_logs(); waits = 2; err_word = -1; both = 1'b0;
    @(negedge clk); miss_req = 1'b1; miss_addr = 32'h00001234;
    @(negedge clk); miss_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (word_idx == 1) break;
      @(negedge clk);
    end
    @(negedge clk); #1;
    n_tests++;
    if (biu_cyc !== 1'b1 || biu_adr !== 32'h00001234) begin
      n_fail++; $display("FAIL abort_pre got cyc=%b adr=%h exp 1 00001234", biu_cyc, biu_adr);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (outs !== 117'd0) begin n_fail++; $display("FAIL abort_outs got %h exp 0", outs); end
    @(negedge clk);
    rst = 1'b1;
    clear_logs(); waits = 0;
    @(negedge clk); miss_req = 1'b1; miss_addr = 32'h00000040;
    @(negedge clk); miss_req = 1'b0;
    @(negedge clk); miss_req = 1'b1; miss_addr = 32'h00000800;
    @(negedge clk);
    @(negedge clk); miss_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (done_cnt != 0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen || ack_cnt != 1) begin
      n_fail++; $display("FAIL abort_restart got done=%b acks=%0d exp 1 1", seen, ack_cnt);
    end
    n_tests++;
    if (adr_log[0] !== 32'h00000040 || n_wr != 2 || wr_addr[0] !== 11'h008 || wr_addr[1] !== 11'h009) begin
      n_fail++; $display("FAIL abort_writes got adr=%h n=%0d %h %h exp 00000040 2 008 009",
                         adr_log[0], n_wr, wr_addr[0], wr_addr[1]);
    end
    n_tests++;
    if (wr_data[0] !== 64'h11111111_22222222 || wr_data[1] !== 64'h33333333_44444444) begin
      n_fail++; $display("FAIL abort_data got %h %h exp 1111111122222222 3333333344444444",
                         wr_data[0], wr_data[1]);
    end
    @(negedge clk); #3;
    n_tests++;
    if (busy !== 1'b0 || ack_cnt != 1) begin
      n_fail++; $display("FAIL abort_idle got busy=%b acks=%0d exp 0 1", busy, ack_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_wait();
    test_err();
    test_ack_err();
    test_wrap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
